// File: rtl/fact_sched.sv
// Two-port round-robin scheduler around a shared iterative factorial datapath.
// One multiply per cycle; result, owner id and sticky overflow are returned on a valid/ready port.
module fact_sched #(
  parameter int WIDTH = 32,
  parameter int N_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [N_W-1:0]   req0_num,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [N_W-1:0]   req1_num,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_ovf,
  input  logic             rsp_ready,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]         state;
  logic               last_grant;
  logic [N_W-1:0]     n_reg;
  logic [WIDTH-1:0]   acc;
  logic [N_W:0]       cnt;
  logic               ovf;
  logic               id;
  logic               grant;
  logic               accept;
  logic [WIDTH+N_W:0] prod;

  // Contention goes to the side that did not win last; otherwise to whoever asks.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end
  end

  assign accept     = (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid && grant;
  assign busy       = (state != IDLE);

  // Full-width product so the bits above WIDTH reveal overflow.
  assign prod = {{(N_W+1){1'b0}}, acc} * {{WIDTH{1'b0}}, cnt};

  // NOTE: state is updated only with non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      n_reg      <= '0;
      acc        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      id         <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            n_reg      <= grant ? req1_num : req0_num;
            acc        <= WIDTH'(1);
            cnt        <= (N_W+1)'(2);
            ovf        <= 1'b0;
            id         <= grant;
            last_grant <= grant;
            state      <= CALC;
          end
        end
        CALC: begin
          // cnt carries one extra bit so n = 2^N_W-1 still terminates.
          if (cnt > {1'b0, n_reg}) begin
            rsp_valid  <= 1'b1;
            rsp_result <= acc;
            rsp_ovf    <= ovf;
            rsp_id     <= id;
            state      <= RESP;
          end else begin
            acc <= prod[WIDTH-1:0];
            ovf <= ovf | (|prod[WIDTH+N_W:WIDTH]);
            cnt <= cnt + (N_W+1)'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fact_sched.sv
// Self-checking bench for fact_sched: directed scenarios plus randomized jobs
// compared against an arithmetic factorial model.
module tb_fact_sched;

  localparam int WIDTH = 32;
  localparam int N_W   = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic [N_W-1:0]   req0_num, req1_num;
  logic             req0_ready, req1_ready;
  logic             rsp_valid, rsp_id, rsp_ovf, rsp_ready, busy;
  logic [WIDTH-1:0] rsp_result;

  int   checks = 0;
  int   errors = 0;
  logic model_last;

  always #5 clk = ~clk;

  fact_sched #(.WIDTH(WIDTH), .N_W(N_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_num(req0_num), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_num(req1_num), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_ovf(rsp_ovf), .rsp_ready(rsp_ready), .busy(busy)
  );

  // n! mod 2^32 by plain arithmetic.
  function automatic logic [WIDTH-1:0] ref_result(input int n);
    bit [63:0] r;
    r = 64'd1;
    for (int i = 2; i <= n; i++) r = (r * 64'(i)) & 64'hFFFF_FFFF;
    return r[31:0];
  endfunction

  // 13! = 6227020800 is the first factorial that exceeds 2^32-1.
  function automatic logic ref_ovf(input int n);
    return (n >= 13);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for the given side to be granted, runs the job and checks the response.
  task automatic serve(input logic side, input bit drop, input int stall, input bit raise_other);
    int               n, waitc, lat, exp_lat;
    logic [WIDTH-1:0] exp_res;
    logic             exp_ovf;
    n         = side ? int'(req1_num) : int'(req0_num);
    exp_lat   = (n < 2) ? 1 : n;
    exp_res   = ref_result(n);
    exp_ovf   = ref_ovf(n);
    rsp_ready = (stall == 0);
    #1;
    waitc = 0;
    while (!(side ? req1_ready : req0_ready) && waitc < 50) begin
      step();
      waitc++;
    end
    checks++;
    if ((side ? req1_ready : req0_ready) !== 1'b1) begin
      errors++;
      $display("FAIL grant side=%0d ready=%0d want=1", side, side ? req1_ready : req0_ready);
      return;
    end
    checks++;
    if ((side ? req0_ready : req1_ready) !== 1'b0) begin
      errors++;
      $display("FAIL grant_exclusive other_ready=%0d want=0", side ? req0_ready : req1_ready);
    end
    step();
    model_last = side;
    if (drop) begin
      if (side) req1_valid = 1'b0; else req0_valid = 1'b0;
    end
    if (raise_other) begin
      if (side) req0_valid = 1'b1; else req1_valid = 1'b1;
    end
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 400) begin
      checks++;
      if (busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL calc_status busy=%0d r0=%0d r1=%0d want 1/0/0", busy, req0_ready, req1_ready);
      end
      step();
      lat++;
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL latency n=%0d got=%0d want=%0d", n, lat, exp_lat);
    end
    checks++;
    if (rsp_result !== exp_res) begin
      errors++;
      $display("FAIL result n=%0d got=%0d want=%0d", n, rsp_result, exp_res);
    end
    checks++;
    if (rsp_id !== side) begin
      errors++;
      $display("FAIL rsp_id n=%0d got=%0d want=%0d", n, rsp_id, side);
    end
    checks++;
    if (rsp_ovf !== exp_ovf) begin
      errors++;
      $display("FAIL rsp_ovf n=%0d got=%0d want=%0d", n, rsp_ovf, exp_ovf);
    end
    for (int s = 0; s < stall; s++) begin
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== exp_res || rsp_id !== side ||
          rsp_ovf !== exp_ovf || req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL hold cyc=%0d valid=%0d res=%0d id=%0d ovf=%0d r0=%0d r1=%0d want 1/%0d/%0d/%0d/0/0",
                 s, rsp_valid, rsp_result, rsp_id, rsp_ovf, req0_ready, req1_ready,
                 exp_res, side, exp_ovf);
      end
    end
    rsp_ready = 1'b1;
    step();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_handshake valid=%0d busy=%0d want 0/0", rsp_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_num   = '0;
    req1_num   = '0;
    rsp_ready  = 1'b1;
    step();
    step();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_ovf !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags valid=%0d id=%0d ovf=%0d busy=%0d want 0", rsp_valid, rsp_id, rsp_ovf, busy);
    end
    checks++;
    if (rsp_result !== '0) begin
      errors++;
      $display("FAIL reset_result got=%0d want=0", rsp_result);
    end
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready r0=%0d r1=%0d want 0", req0_ready, req1_ready);
    end
    rst_n      = 1'b1;
    model_last = 1'b1;
  endtask

  task automatic test_single();
    req0_num   = 8'd5;
    req0_valid = 1'b1;
    serve(1'b0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_small();
    req1_num   = 8'd0;
    req1_valid = 1'b1;
    serve(1'b1, 1'b1, 0, 1'b0);
    req1_num   = 8'd1;
    req1_valid = 1'b1;
    serve(1'b1, 1'b1, 0, 1'b0);
  endtask

  task automatic test_contention();
    req0_num   = 8'd4;
    req1_num   = 8'd3;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      serve(k[0], 1'b0, 0, 1'b0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_boundary();
    req0_num   = 8'd12;
    req0_valid = 1'b1;
    serve(1'b0, 1'b1, 0, 1'b0);
    req0_num   = 8'd13;
    req0_valid = 1'b1;
    serve(1'b0, 1'b1, 0, 1'b0);
    req1_num   = 8'd255;
    req1_valid = 1'b1;
    serve(1'b1, 1'b1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    req0_num   = 8'd6;
    req1_num   = 8'd2;
    req0_valid = 1'b1;
    serve(1'b0, 1'b1, 10, 1'b1);
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL bubble_turnaround r1=%0d want=1", req1_ready);
    end
    serve(1'b1, 1'b1, 0, 1'b0);
  endtask

  task automatic test_mid_reset();
    req0_num   = 8'd7;
    req0_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_accept r0=%0d want=1", req0_ready);
    end
    step();
    req0_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n      = 1'b1;
    model_last = 1'b1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state valid=%0d busy=%0d want 0/0", rsp_valid, busy);
    end
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midrst_quiet cyc=%0d valid=%0d busy=%0d want 0/0", c, rsp_valid, busy);
      end
    end
    req0_num   = 8'd3;
    req1_num   = 8'd2;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    serve(1'b0, 1'b1, 0, 1'b0);
    serve(1'b1, 1'b1, 0, 1'b0);
  endtask

  task automatic test_random();
    int   p, st;
    logic first;
    for (int it = 0; it < 24; it++) begin
      p        = $urandom_range(0, 2);
      st       = $urandom_range(0, 3);
      req0_num = N_W'($urandom_range(0, 40));
      req1_num = N_W'($urandom_range(0, 40));
      if (p == 0) begin
        req0_valid = 1'b1;
        serve(1'b0, 1'b1, st, 1'b0);
      end else if (p == 1) begin
        req1_valid = 1'b1;
        serve(1'b1, 1'b1, st, 1'b0);
      end else begin
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        first = ~model_last;
        serve(first, 1'b1, st, 1'b0);
        serve(~first, 1'b1, st, 1'b0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_small();
    test_contention();
    test_boundary();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fact_sched.md
Name: fact_sched

Overview:
- Scheduler and controller for a shared iterative factorial datapath: one multiplier/accumulator loop, two requesters.
- Accepts factorial jobs from two valid/ready request ports and arbitrates round-robin.
- Sequences one multiply per cycle, then returns the result with requester ID and overflow flag on a valid/ready response port.
- Sits between job sources (bench or upstream logic driving a number) and the consumer of the result.

Parameters:
WIDTH, 32, result/accumulator width in bits
N_W, 8, width of requested operand num

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
req0_valid  input  1  requester 0 has a job
req0_num  input  N_W  requester 0 operand n (compute n!)
req0_ready  output  1  requester 0 job accepted this cycle when high with req0_valid
req1_valid  input  1  requester 1 has a job
req1_num  input  N_W  requester 1 operand
req1_ready  output  1  requester 1 accept
rsp_valid  output  1  response available
rsp_id  output  1  requester that owns the response (0/1)
rsp_result  output  WIDTH  n! mod 2^WIDTH
rsp_ovf  output  1  true n! did not fit in WIDTH bits
rsp_ready  input  1  consumer accepts response
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is synchronous and active-low.
- Reset values: state=IDLE; rsp_valid=0, rsp_id=0, rsp_result=0, rsp_ovf=0, busy=0; last_grant=1, so req0 wins the first contention.
- FSM states IDLE, CALC, RESP.
- IDLE:
  - Grant logic: if only one reqX_valid, grant X. If both, grant the requester != last_grant.
  - reqX_ready=1 combinationally for the granted requester only; both ready=0 outside IDLE.
  - On accept (valid&&ready): latch n_reg=num, acc=1, cnt=2, ovf=0, id=X, last_grant=X; go to CALC.
- CALC:
  - Each cycle: if cnt > n_reg, go to RESP and drive rsp_valid=1, rsp_result=acc, rsp_ovf=ovf, rsp_id=id (all registered).
  - Otherwise: acc <= low WIDTH bits of acc*cnt; ovf <= ovf | (upper bits of full product != 0); cnt <= cnt+1.
  - cnt is N_W+1 bits wide so n=2^N_W-1 terminates without wrap.
  - Product is computed at full width WIDTH+N_W+1.
- Latency: rsp_valid rises max(n,1) cycles after the accept edge. n=0 and n=1 both return 1, ovf=0, after 1 cycle.
- RESP:
  - rsp_* held stable until rsp_valid&&rsp_ready.
  - On handshake: rsp_valid<=0, go to IDLE. The next job can be accepted no earlier than the following cycle (one bubble; no same-cycle turnaround).
- Backpressure: rsp_ready low holds the FSM in RESP indefinitely; no new jobs are accepted.
- Request protocol: requester holds valid and num stable until ready. The block samples num only at accept.
- Overflow is sticky per job. Once set, it stays set even if the truncated acc later becomes 0 (e.g. large n with WIDTH small).
- Reset mid-operation (any state): the in-flight job is discarded with no response; all registers return to reset values on that edge.
- rsp_valid=0 during CALC and IDLE. busy=1 in CALC and RESP.

Test Plan:
- req0 num=5 alone, rsp_ready=1 -> req0_ready high one cycle; rsp_valid 5 cycles after accept; result=120, id=0, ovf=0; busy low after handshake.
- req1 num=0, then num=1 -> each result=1, ovf=0, latency 1 cycle, id=1.
- req0 num=4 and req1 num=3 both held valid continuously -> grant order 0,1,0,1; results 24 (id 0) and 6 (id 1) alternating; never two consecutive grants to the same side.
- WIDTH=32: num=12 -> 479001600, ovf=0; num=13 -> 1932053504, ovf=1; num=255 -> completes in 255 cycles, ovf=1, no hang.
- Response for num=6 with rsp_ready low 10 cycles -> rsp_valid/result=720/id stable throughout; req0_ready and req1_ready stay 0 while requests pend; release -> handshake, next job accepted 1 cycle later.
- rst_n low one cycle during CALC of num=7 -> next cycle state IDLE, rsp_valid=0, busy=0, no response emitted. Then both requesters valid (num 3 and 2) -> req0 served first, result 6, then req1 result 2.
